// File: rtl/divider_4_port_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : divider_4_port_peripheral
// Brief    : 4-bit unsigned repeated-subtraction divider on the KCPSM6 port bus
// Revision : 1.0 - initial release
// ============================================================================
module divider_4_port_peripheral (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       k_write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic [3:0] Quotient,
    output logic [3:0] Remainder,
    output logic       Done,
    output logic       Qi,
    output logic       Qc,
    output logic       Qd,
    output logic       DivZero
);

    typedef enum logic [1:0] {
        S_INITIAL = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_operand;
    logic [7:0] w_operand_next;
    logic [3:0] r_xw;
    logic [3:0] w_xw_next;
    logic [3:0] r_quot;
    logic [3:0] w_quot_next;
    logic [3:0] r_rem;
    logic [3:0] w_rem_next;
    logic       r_divzero;
    logic       w_divzero_next;

    logic       w_op_write;
    logic       w_start;
    logic       w_ack;
    logic       w_status_read;
    logic [3:0] w_x;
    logic [3:0] w_y;

    assign w_x           = r_operand[7:4];
    assign w_y           = r_operand[3:0];
    assign w_op_write    = write_strobe   && (port_id[1:0] == 2'd0);
    assign w_start       = k_write_strobe && (port_id[1:0] == 2'd1) && out_port[0];
    assign w_ack         = k_write_strobe && (port_id[1:0] == 2'd1) && out_port[1];
    assign w_status_read = read_strobe    && (port_id[1:0] == 2'd1);

    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_INITIAL;
            r_operand <= 8'h00;
            r_xw      <= 4'h0;
            r_quot    <= 4'h0;
            r_rem     <= 4'h0;
            r_divzero <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_operand <= w_operand_next;
            r_xw      <= w_xw_next;
            r_quot    <= w_quot_next;
            r_rem     <= w_rem_next;
            r_divzero <= w_divzero_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_operand_next = r_operand;
        w_xw_next      = r_xw;
        w_quot_next    = r_quot;
        w_rem_next     = r_rem;
        w_divzero_next = r_divzero;

        // Clear-on-read first so a divide-by-zero set below takes priority
        if (w_status_read) begin
            w_divzero_next = 1'b0;
        end

        case (r_state)
            S_INITIAL: begin
                if (w_op_write) begin
                    w_operand_next = out_port;
                end
                if (w_start) begin
                    w_xw_next = w_x;
                    if (w_y == 4'h0) begin
                        w_state_next   = S_DONE;
                        w_quot_next    = 4'hF;
                        w_rem_next     = w_x;
                        w_divzero_next = 1'b1;
                    end else begin
                        w_state_next = S_COMPUTE;
                        w_quot_next  = 4'h0;
                        w_rem_next   = 4'h0;
                    end
                end
            end
            S_COMPUTE: begin
                // Compare before subtracting so the working dividend never underflows
                if (r_xw >= w_y) begin
                    w_xw_next   = r_xw - w_y;
                    w_quot_next = r_quot + 4'h1;
                end else begin
                    w_rem_next   = r_xw;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_ack) begin
                    w_state_next = S_INITIAL;
                end
            end
            default: begin
                w_state_next = S_INITIAL;
            end
        endcase
    end

    assign Qi        = (r_state == S_INITIAL);
    assign Qc        = (r_state == S_COMPUTE);
    assign Qd        = (r_state == S_DONE);
    assign Done      = Qd;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign DivZero   = r_divzero;

    always_comb begin
        in_port = 8'h00;
        case (port_id[1:0])
            2'd0:    in_port = {r_quot, r_rem};
            2'd1:    in_port = {3'b000, r_divzero, Qd, Qc, Qi, Done};
            2'd2:    in_port = r_operand;
            default: in_port = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_4_port_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_4_port_peripheral
// Brief    : scoreboard bench for the port-mapped 4-bit divider
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_4_port_peripheral;

    logic       ClkPort;
    logic       Reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic [3:0] Quotient;
    logic [3:0] Remainder;
    logic       Done;
    logic       Qi;
    logic       Qc;
    logic       Qd;
    logic       DivZero;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_rd_val[$];
    string      exp_rd_tag[$];
    logic [7:0] exp_res_val[$];
    int         exp_res_cyc[$];

    divider_4_port_peripheral dut (
        .ClkPort        (ClkPort),
        .Reset          (Reset),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port),
        .Quotient       (Quotient),
        .Remainder      (Remainder),
        .Done           (Done),
        .Qi             (Qi),
        .Qc             (Qc),
        .Qd             (Qd),
        .DivZero        (DivZero)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: read responses and completed divisions are checked against the queues
    logic prev_done = 1'b0;
    int   qc_count  = 0;
    always @(negedge ClkPort) begin
        if (read_strobe) begin
            if (exp_rd_val.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got %02h expected none", in_port);
            end else begin
                chk(exp_rd_tag.pop_front(), in_port, exp_rd_val.pop_front());
            end
        end
        if (Qi) qc_count = 0;
        if (Qc) qc_count++;
        if (Done && !prev_done) begin
            if (exp_res_val.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_unexpected: got %02h expected none", {Quotient, Remainder});
            end else begin
                chk("result", {Quotient, Remainder}, exp_res_val.pop_front());
                chk("compute_cycles", 8'(qc_count), 8'(exp_res_cyc.pop_front()));
            end
        end
        prev_done = Done;
    end

    task automatic cyc();
        @(posedge ClkPort);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        port_id = 8'h00; out_port = d; write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        port_id = 8'h01; out_port = d; k_write_strobe = 1'b1;
        cyc();
        k_write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] exp, input string tag);
        port_id = p; read_strobe = 1'b1;
        exp_rd_val.push_back(exp);
        exp_rd_tag.push_back(tag);
        cyc();
        read_strobe = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!Done && n < 40) begin
            cyc();
            n++;
        end
        if (!Done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got Done=0 expected Done=1", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
        repeat (2) cyc();
        chk("rst_flags", {3'b000, DivZero, Qd, Qc, Qi, Done}, 8'h02);
        chk("rst_result", in_port, 8'h00);
        Reset = 1'b1;
        cyc();
        rd(8'h01, 8'h02, "init_status");
        rd(8'h02, 8'h00, "init_operand");
        rd(8'h03, 8'h00, "port3");

        // 13/4 = 3 r1; ignored write and Ack while computing
        wr(8'hD4);
        cmd(8'h01);
        exp_res_val.push_back(8'h31); exp_res_cyc.push_back(4);
        rd(8'h01, 8'h04, "compute_status");
        wr(8'h21);
        cmd(8'h02);
        wait_done("d4");
        rd(8'h02, 8'hD4, "operand_hold");
        rd(8'h00, 8'h31, "d4_result");
        rd(8'h01, 8'h09, "done_status");
        cmd(8'h01);
        rd(8'h01, 8'h09, "start_in_done");
        cmd(8'h02);
        rd(8'h01, 8'h02, "ack_status");
        rd(8'h00, 8'h31, "result_hold");

        // 15/1 = 15 r0, then combined Start+Ack in DONE
        wr(8'hF1);
        cmd(8'h01);
        exp_res_val.push_back(8'hF0); exp_res_cyc.push_back(16);
        wait_done("f1");
        rd(8'h00, 8'hF0, "f1_result");
        cmd(8'h03);
        rd(8'h01, 8'h02, "both_in_done");

        // 3/7 = 0 r3 via combined Start+Ack in INITIAL
        wr(8'h37);
        cmd(8'h03);
        exp_res_val.push_back(8'h03); exp_res_cyc.push_back(1);
        rd(8'h01, 8'h04, "both_in_init");
        wait_done("37");
        rd(8'h00, 8'h03, "37_result");
        cmd(8'h02);

        // 9/0: DONE on the next edge, sticky flag, clear-on-read
        wr(8'h90);
        cmd(8'h01);
        exp_res_val.push_back(8'hF9); exp_res_cyc.push_back(0);
        rd(8'h01, 8'h19, "dz_status");
        rd(8'h01, 8'h09, "dz_cleared");
        rd(8'h00, 8'hF9, "dz_result");
        cmd(8'h02);
        rd(8'h01, 8'h02, "dz_ack");

        // Divide-by-zero set and clear-on-read on the same edge
        wr(8'h50);
        port_id = 8'h01; out_port = 8'h01; k_write_strobe = 1'b1; read_strobe = 1'b1;
        exp_rd_val.push_back(8'h02); exp_rd_tag.push_back("set_clr_pre");
        exp_res_val.push_back(8'hF5); exp_res_cyc.push_back(0);
        cyc();
        k_write_strobe = 1'b0; read_strobe = 1'b0;
        rd(8'h01, 8'h19, "set_wins");
        rd(8'h01, 8'h09, "set_wins_clr");
        cmd(8'h02);

        // Asynchronous reset in the middle of a computation
        wr(8'hF1);
        cmd(8'h01);
        repeat (3) cyc();
        port_id = 8'h00;
        Reset = 1'b0;
        #2;
        chk("midrst_flags", {3'b000, DivZero, Qd, Qc, Qi, Done}, 8'h02);
        chk("midrst_result", in_port, 8'h00);
        port_id = 8'h02;
        #1;
        chk("midrst_operand", in_port, 8'h00);
        cyc();
        Reset = 1'b1;
        cyc();
        rd(8'h01, 8'h02, "post_rst_status");
        repeat (2) cyc();

        chk("rd_queue_empty", 8'(exp_rd_val.size()), 8'd0);
        chk("res_queue_empty", 8'(exp_res_val.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
